// File: rtl/s4ga_cfg_pkg.sv
// Shared types and helpers for the s4ga configuration sequencer.
package s4ga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRE    = 2'd1,
    STREAM = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // CRC-8, MSB first, no reflection, one whole byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s4ga_cfg_nibbler.sv
// Byte buffer and nibble serializer: low nibble goes out the cycle after a
// byte is accepted, high nibble the cycle after that. A new byte can be taken
// while the high nibble is on the output, so back-to-back bytes never bubble.
module s4ga_cfg_nibbler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       more,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic       load,
  output logic       stall,
  output logic       fab_ce,
  output logic [3:0] fab_si
);

  logic [3:0] hi_q;
  logic       full;
  logic       hi_out;
  logic       accept;

  // Ready when the buffer is free or its last nibble is leaving this cycle.
  always_comb begin
    cfg_ready = en & more & (~full | hi_out);
    accept    = cfg_valid & cfg_ready;
    load      = accept | (en & full & ~hi_out);
    stall     = en & more & ~load;
  end

  // Output register and buffer bookkeeping; fab_si holds on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      full   <= 1'b0;
      hi_out <= 1'b0;
      fab_ce <= 1'b0;
      fab_si <= '0;
    end else if (!en) begin
      full   <= 1'b0;
      hi_out <= 1'b0;
      fab_ce <= 1'b0;
    end else if (accept) begin
      hi_q   <= cfg_data[7:4];
      full   <= 1'b1;
      hi_out <= 1'b0;
      fab_ce <= 1'b1;
      fab_si <= cfg_data[3:0];
    end else if (full && !hi_out) begin
      hi_out <= 1'b1;
      fab_ce <= 1'b1;
      fab_si <= hi_q;
    end else begin
      full   <= 1'b0;
      hi_out <= 1'b0;
      fab_ce <= 1'b0;
    end
  end

endmodule

// File: rtl/s4ga_cfg_sequencer.sv
// s4ga configuration sequencer: reset preamble, then streams host bytes to
// the fabric as nibbles for nframes frames.
// Optional: define S4GA_CFG_CRC_EN to add a CRC-8 of all accepted bytes.
//
// state  | meaning
// IDLE   | fabric held in reset, waiting for start
// PRE    | reset preamble, RST_CYCLES cycles
// STREAM | fabric out of reset, nibbles streamed
// FIN    | one-cycle done pulse, back to IDLE
module s4ga_cfg_sequencer
  import s4ga_cfg_pkg::*;
#(
  parameter int FRAME_NIBBLES = 64,
  parameter int RST_CYCLES    = 2,
  parameter int FRAME_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] nframes,
  input  logic [7:0]         cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic               fab_rst,
  output logic               fab_ce,
  output logic [3:0]         fab_si,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               underrun
`ifdef S4GA_CFG_CRC_EN
  ,
  output logic [7:0]         crc
`endif
);

  localparam int BYTES_PER_FRAME = FRAME_NIBBLES / 2;
  localparam int NIB_W   = $clog2(FRAME_NIBBLES);
  localparam int BYTES_W = FRAME_W + NIB_W;
  localparam int PRE_W   = $clog2(RST_CYCLES) + 1;

  state_t             state, state_next;
  logic [FRAME_W-1:0] nframes_q;
  logic [BYTES_W-1:0] bytes_left;
  logic [NIB_W-1:0]   nib_cnt;
  logic [PRE_W-1:0]   pre_cnt;
  logic               start_ok;
  logic               accept;
  logic               load;
  logic               stall;

  s4ga_cfg_nibbler u_nibbler (
    .clk       (clk),
    .rst       (rst),
    .en        (state == STREAM),
    .more      (bytes_left != '0),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .load      (load),
    .stall     (stall),
    .fab_ce    (fab_ce),
    .fab_si    (fab_si)
  );

  assign start_ok = (state == IDLE) & start;
  assign accept   = cfg_valid & cfg_ready;

  // Next-state decode; STREAM ends on the cycle its last nibble is shown,
  // which is when frame_idx reaches the requested count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (nframes == '0) ? FIN : PRE;
      PRE:     if (pre_cnt == '0) state_next = STREAM;
      STREAM:  if (frame_idx == nframes_q) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered status outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fab_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      fab_rst <= (state_next != STREAM);
      busy    <= (state_next == PRE) || (state_next == STREAM);
      done    <= (state_next == FIN);
    end
  end

  // Run counters: preamble and byte budget count down, nibbles count up.
  always_ff @(posedge clk) begin
    if (rst) begin
      nframes_q  <= '0;
      bytes_left <= '0;
      pre_cnt    <= '0;
      nib_cnt    <= '0;
      frame_idx  <= '0;
      underrun   <= 1'b0;
    end else if (start_ok) begin
      nframes_q  <= nframes;
      bytes_left <= BYTES_W'(nframes) * BYTES_W'(BYTES_PER_FRAME);
      pre_cnt    <= PRE_W'(RST_CYCLES - 1);
      nib_cnt    <= '0;
      frame_idx  <= '0;
      underrun   <= 1'b0;
    end else begin
      if (state == PRE && pre_cnt != '0) pre_cnt <= pre_cnt - PRE_W'(1);
      if (accept) bytes_left <= bytes_left - BYTES_W'(1);
      if (stall) underrun <= 1'b1;
      if (load) begin
        if (nib_cnt == NIB_W'(FRAME_NIBBLES - 1)) begin
          nib_cnt   <= '0;
          frame_idx <= frame_idx + FRAME_W'(1);
        end else begin
          nib_cnt <= nib_cnt + NIB_W'(1);
        end
      end
    end
  end

`ifdef S4GA_CFG_CRC_EN
  // Running CRC over every byte the sequencer accepts in the current run.
  always_ff @(posedge clk) begin
    if (rst || start_ok) crc <= '0;
    else if (accept) crc <= crc8_byte(crc, cfg_data);
  end
`endif

endmodule

// File: doc/s4ga_cfg_sequencer.md
Name: s4ga_cfg_sequencer

Overview:
Configuration sequencer for the s4ga fabric, which takes 4 config bits per clock on si[3:0].
- Accepts config bytes from a host over a valid/ready handshake.
- Holds the fabric in reset for a programmable preamble.
- Serializes each byte low nibble first, one nibble per enabled fabric cycle, for a requested number of frames.
- Sits between the host/bridge and the s4ga instance inside the top-level wrapper.

Parameters:
FRAME_NIBBLES, 64, nibbles per config frame; must be even and ≥2 (frame = FRAME_NIBBLES/2 bytes).
RST_CYCLES, 2, cycles fab_rst is held high after start before streaming; ≥1.
FRAME_W, 8, width of frame count and frame index.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle request to begin a run; ignored while busy.
nframes  in  FRAME_W  frames to stream; sampled when start is accepted.
cfg_data  in  8  config byte.
cfg_valid  in  1  cfg_data valid.
cfg_ready  out  1  sequencer accepts byte this cycle.
fab_rst  out  1  to s4ga rst.
fab_ce  out  1  fabric clock enable; fab_si is consumed only when high.
fab_si  out  4  to s4ga si[3:0].
busy  out  1  run in progress.
done  out  1  one-cycle pulse at end of run.
frame_idx  out  FRAME_W  frames fully streamed in current run.
underrun  out  1  sticky: a stall occurred during streaming; cleared on start.

Behaviour:
- Reset values: fab_rst=1, fab_ce=0, fab_si=0, cfg_ready=0, busy=0, done=0, frame_idx=0, underrun=0, state=IDLE.
- Reset mid-run aborts immediately; any held byte is discarded.
- All outputs are registered except cfg_ready. cfg_ready is decoded combinationally from state and buffer.

States: IDLE, PRE, STREAM, FIN.
- IDLE:
  - fab_rst=1, busy=0.
  - start=1: latch nframes, clear frame_idx and underrun.
  - If nframes==0, go to FIN; otherwise load preamble counter and go to PRE.
- PRE:
  - fab_rst=1, busy=1, fab_ce=0.
  - Stays RST_CYCLES cycles, then goes to STREAM.
  - cfg_ready=0 throughout.
- STREAM:
  - fab_rst=0, busy=1.
  - One-byte buffer with phase bit (LO/HI).
  - cfg_ready=1 when the buffer is empty, or its HI nibble is being emitted this cycle, AND un-accepted bytes remain in the run (nframes*FRAME_NIBBLES/2 total).
- Byte timing:
  - Byte accepted at cycle t (cfg_valid&cfg_ready): fab_si=data[3:0], fab_ce=1 at t+1; fab_si=data[7:4], fab_ce=1 at t+2.
  - Back-to-back acceptance gives one nibble every cycle with no bubbles.
- Stall:
  - A STREAM cycle with no nibble to emit drives fab_ce=0, holds fab_si at its previous value, and sets underrun.
  - The wait for the very first byte of the run also counts as a stall.
- Frame accounting:
  - Nibble counter increments on each fab_ce=1 cycle.
  - At FRAME_NIBBLES-1 it wraps to 0 and frame_idx increments in the same cycle as that last nibble.
  - No gap between frames; a byte never straddles a frame, because FRAME_NIBBLES is even.
- Last nibble of last frame: go to FIN next cycle.
- FIN: done=1 for exactly one cycle, busy=0, fab_rst=1, fab_ce=0, then IDLE.
- A start in the same cycle as FIN is ignored.
- frame_idx holds its final value until the next accepted start.
- cfg_valid in IDLE/PRE/FIN is never acknowledged.

Optional Feature:
S4GA_CFG_CRC_EN.
- When defined: adds output crc (8 bits), a CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no xorout) over every accepted byte. It is cleared on accepted start and on rst, updated in the acceptance cycle, and read-valid once done pulses.
- When undefined: no crc port and no CRC logic.

Decomposition:
- Package s4ga_cfg_pkg holds:
  - state enum (IDLE/PRE/STREAM/FIN);
  - CRC8_POLY=8'h07;
  - function crc8_byte(crc, data).
- One sub-module, s4ga_cfg_nibbler: byte buffer, phase bit and cfg_ready/fab_ce/fab_si generation.
- The FSM, counters and CRC stay in the top module.

Test Plan:
1. Reset values, then FRAME_NIBBLES=4, nframes=1, start, bytes 0x21,0x43 with cfg_valid held → fab_rst high 2 cycles, then fab_si 1,2,3,4 with fab_ce=1 on consecutive cycles, frame_idx=1, single done pulse, underrun=0.
2. nframes=3, FRAME_NIBBLES=4, source deasserts cfg_valid 2 cycles mid-frame 2 → fab_ce=0 those cycles, fab_si held, underrun=1, 12 nibbles total in order, frame_idx=3, done once.
3. nframes=0 → FIN the cycle after start, done pulse, cfg_ready never high, fab_rst never drops.
4. rst asserted mid-STREAM after 3 nibbles → next cycle all outputs at reset values; fresh run then streams correctly from nibble 0.
5. start pulsed while busy, and cfg_valid high in IDLE → no effect, no byte acknowledged.
6. S4GA_CFG_CRC_EN, FRAME_NIBBLES=18, nframes=1, bytes ASCII "123456789" → crc=8'hF4 at done.
